// File: rtl/alureg_pkg.sv
// Package shared by the register-file/ALU micro-sequencer.
// Holds the controller FSM state type, the instruction kind codes and the
// 2-bit ALU operation codes understood by the 8x16 datapath ALU.
package alureg_pkg;

  // One state per datapath phase; IDLE is the only state that accepts work.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Instruction kinds carried on instr_kind.
  localparam logic KIND_LOADI = 1'b0;
  localparam logic KIND_ALU   = 1'b1;

  // ALU operation codes, passed straight through to the datapath ALU.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/alureg_seq_ctrl.sv
// alureg_seq_ctrl: micro-sequencer for the 8x16 register-file/ALU datapath.
// Accepts one instruction at a time over instr_valid/instr_ready and runs it:
//   LOADI : write instr_imm into register rd (one write cycle).
//   ALU   : EXEC/WB pair repeated rep+1 times; each EXEC re-reads the source
//           registers, so rd==rs1 accumulates.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   instr_valid / instr_ready  instruction handshake (ready only in IDLE)
//   instr_kind/op/rd/rs1/rs2/rep/imm  instruction fields, latched at accept
//   op, rd_addr_a, rd_addr_b, wr_addr, wr, sel, d_in   datapath controls
//   alu_out, cout              datapath ALU result and carry
//   result                     last value written by LOADI/ALU
//   carry_flag                 sticky "carry seen in this instruction"
//   done                       one-cycle completion pulse
//   busy                       high in any state other than IDLE
// Build option: define ALUREG_SEQ_CARRY_EN to enable the sticky carry_flag;
// without it carry_flag is tied to 0 and cout is ignored.
module alureg_seq_ctrl
  import alureg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_kind,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [REP_W-1:0]  instr_rep,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr,
  output logic              sel,
  output logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              cout,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              done,
  output logic              busy
);

  state_t              state;
  state_t              next_state;
  logic                accept;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [REP_W-1:0]    iter;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign accept      = instr_valid && instr_ready;

  // Next-state logic. The iteration counter is tested before it is
  // decremented, so rep+1 EXEC/WB passes run and the counter never wraps.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = (instr_kind == KIND_LOADI) ? ST_LOAD : ST_EXEC;
        end
      end
      ST_LOAD: next_state = ST_DONE;
      ST_EXEC: next_state = ST_WB;
      ST_WB:   next_state = (iter == '0) ? ST_DONE : ST_EXEC;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register plus the registered datapath controls. Each control is
  // loaded on the edge that enters the state it belongs to, so it is valid
  // for the whole of that state. On accept the controls come straight from
  // the instr_* inputs because the latched copies are not yet available.
  // wr defaults low every cycle; everything else holds its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_q      <= '0;
      imm_q     <= '0;
      iter      <= '0;
      op        <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      wr_addr   <= '0;
      wr        <= 1'b0;
      sel       <= 1'b0;
      d_in      <= '0;
      result    <= '0;
    end else begin
      state <= next_state;
      wr    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q  <= instr_rd;
            imm_q <= instr_imm;
            iter  <= instr_rep;
            if (instr_kind == KIND_LOADI) begin
              wr      <= 1'b1;
              sel     <= 1'b0;
              d_in    <= instr_imm;
              wr_addr <= instr_rd;
            end else begin
              rd_addr_a <= instr_rs1;
              rd_addr_b <= instr_rs2;
              op        <= instr_op;
            end
          end
        end
        ST_LOAD: begin
          result <= imm_q;
        end
        ST_EXEC: begin
          wr      <= 1'b1;
          sel     <= 1'b1;
          wr_addr <= rd_q;
        end
        ST_WB: begin
          result <= alu_out;
          if (iter != '0) begin
            iter <= iter - REP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALUREG_SEQ_CARRY_EN
  logic carry_q;

  // Sticky carry: cleared when a new instruction is accepted, set by any
  // write-back that produced a carry. LOADI never reaches WB, so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if (state == ST_WB && cout) begin
      carry_q <= 1'b1;
    end
  end

  assign carry_flag = carry_q;
`else
  logic unused_cout;

  assign unused_cout = cout;
  assign carry_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alureg_seq_ctrl.sv
// Testbench for alureg_seq_ctrl. Surrounds the controller with a small
// behavioural register file / ALU and compares the whole instruction outcome
// (latency, write count, register contents, result, carry) against a
// reference model that simply executes each instruction with arithmetic.
module tb_alureg_seq_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          instr_kind = 1'b0;
  logic [1:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic [RW-1:0] instr_rep = '0;
  logic [DW-1:0] instr_imm = '0;
  logic [1:0]    op;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-1:0] wr_addr;
  logic          wr;
  logic          sel;
  logic [DW-1:0] d_in;
  logic [DW-1:0] alu_out;
  logic          cout;
  logic [DW-1:0] result;
  logic          carry_flag;
  logic          done;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment register file and write monitor.
  logic [DW-1:0] regs [8] = '{default: 16'h0};
  int            wr_total = 0;
  logic          last_sel = 1'b0;
  logic [DW-1:0] last_din = '0;
  logic [AW-1:0] last_addr = '0;
  int            wr_base = 0;

  // Reference model register file.
  logic [DW-1:0] model_regs [8];

  alureg_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .REP_W(RW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_kind(instr_kind), .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rep(instr_rep),
    .instr_imm(instr_imm),
    .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
    .wr(wr), .sel(sel), .d_in(d_in),
    .alu_out(alu_out), .cout(cout),
    .result(result), .carry_flag(carry_flag), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath ALU: {carry, value}. SUB reports the borrow as carry.
  function automatic logic [DW:0] alu_fn(input logic [1:0] f,
                                         input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (f)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {cout, alu_out} = alu_fn(op, regs[rd_addr_a], regs[rd_addr_b]);

  always @(posedge clk) begin
    if (wr) begin
      regs[wr_addr] <= sel ? alu_out : d_in;
      wr_total      <= wr_total + 1;
      last_sel      <= sel;
      last_din      <= d_in;
      last_addr     <= wr_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Executes one instruction on the model register file; iter_limit lets
  // an instruction be cut short (reset abandons the rest).
  task automatic model_run(input logic kind, input logic [1:0] f,
                           input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic [RW-1:0] rep,
                           input logic [DW-1:0] imm, input int iter_limit,
                           output int lat, output int nwr,
                           output logic [DW-1:0] res, output logic c);
    logic [DW:0] r;
    c = 1'b0;
    res = '0;
    if (kind == 1'b0) begin
      model_regs[rd] = imm;
      res = imm;
      lat = 2;
      nwr = 1;
    end else begin
      for (int k = 0; k <= int'(rep) && k < iter_limit; k++) begin
        r = alu_fn(f, model_regs[rs1], model_regs[rs2]);
        model_regs[rd] = r[DW-1:0];
        res = r[DW-1:0];
        c = c | r[DW];
      end
      lat = 2 * (int'(rep) + 1) + 1;
      nwr = int'(rep) + 1;
    end
`ifndef ALUREG_SEQ_CARRY_EN
    c = 1'b0;
`endif
  endtask

  // Presents an instruction, waits (bounded) for acceptance, then scrambles
  // the fields to prove they were latched.
  task automatic apply_stimulus(input logic kind, input logic [1:0] f,
                                input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                input logic [AW-1:0] rs2, input logic [RW-1:0] rep,
                                input logic [DW-1:0] imm, input bit hold);
    int waitc = 0;
    @(negedge clk);
    instr_kind = kind; instr_op = f; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_rep = rep; instr_imm = imm;
    instr_valid = 1'b1;
    while (!instr_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_accept", 32'(instr_ready), 32'd1);
    wr_base = wr_total;
    @(posedge clk);
    #1;
    instr_kind = 1'($urandom); instr_op = 2'($urandom);
    instr_rd = 3'($urandom); instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
    instr_rep = 4'($urandom); instr_imm = 16'($urandom);
    instr_valid = hold;
  endtask

  task automatic check_output(input int lat, input int nwr,
                              input logic [DW-1:0] res, input logic c,
                              input bit tail);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n + 1), 32'(lat));
    check("wr_pulses", 32'(wr_total - wr_base), 32'(nwr));
    check("result", 32'(result), 32'(res));
    check("carry_flag", 32'(carry_flag), 32'(c));
    check("busy_in_done", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("reg%0d", i), 32'(regs[i]), 32'(model_regs[i]));
    end
    if (tail) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("ready_after_done", 32'(instr_ready), 32'd1);
    end
  endtask

  task automatic do_instr(input logic kind, input logic [1:0] f,
                          input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [RW-1:0] rep,
                          input logic [DW-1:0] imm);
    int lat, nwr;
    logic [DW-1:0] res;
    logic c;
    model_run(kind, f, rd, rs1, rs2, rep, imm, 1000, lat, nwr, res, c);
    apply_stimulus(kind, f, rd, rs1, rs2, rep, imm, 1'b0);
    check_output(lat, nwr, res, c, 1'b1);
  endtask

  initial begin
    int lat, nwr, lat2, nwr2, seen;
    logic [DW-1:0] res, res2;
    logic c, c2;

    for (int i = 0; i < 8; i++) model_regs[i] = '0;

    // Reset state.
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_addrs", {23'd0, rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
    check("rst_din", 32'(d_in), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // LOADI r2 = 1234.
    do_instr(1'b0, 2'd0, 3'd2, 3'd0, 3'd0, 4'd0, 16'h1234);
    check("loadi_sel", 32'(last_sel), 32'd0);
    check("loadi_din", 32'(last_din), 32'h1234);
    check("loadi_addr", 32'(last_addr), 32'd2);

    // ALU add r3 = r1 + r2 with 5 + 7.
    do_instr(1'b0, 2'd0, 3'd1, 3'd0, 3'd0, 4'd0, 16'd5);
    do_instr(1'b0, 2'd0, 3'd2, 3'd0, 3'd0, 4'd0, 16'd7);
    do_instr(1'b1, 2'd0, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0);
    check("alu_sel", 32'(last_sel), 32'd1);
    check("alu_addr", 32'(last_addr), 32'd3);

    // Accumulate r1 += r2, four passes.
    do_instr(1'b0, 2'd0, 3'd1, 3'd0, 3'd0, 4'd0, 16'd1);
    do_instr(1'b0, 2'd0, 3'd2, 3'd0, 3'd0, 4'd0, 16'd1);
    do_instr(1'b1, 2'd0, 3'd1, 3'd1, 3'd2, 4'd3, 16'h0);

    // Carry out of FFFF + 1, then a LOADI must clear it.
    do_instr(1'b0, 2'd0, 3'd1, 3'd0, 3'd0, 4'd0, 16'hFFFF);
    do_instr(1'b0, 2'd0, 3'd2, 3'd0, 3'd0, 4'd0, 16'd1);
    do_instr(1'b1, 2'd0, 3'd3, 3'd1, 3'd2, 4'd0, 16'h0);
    do_instr(1'b0, 2'd0, 3'd4, 3'd0, 3'd0, 4'd0, 16'h0055);

    // Maximum repeat count: 16 passes of r7 += r0 (r0 = 1).
    do_instr(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 4'd0, 16'd1);
    do_instr(1'b0, 2'd0, 3'd7, 3'd0, 3'd0, 4'd0, 16'd0);
    do_instr(1'b1, 2'd0, 3'd7, 3'd7, 3'd0, 4'd15, 16'h0);

    // Back-to-back with instr_valid held; second fields appear while busy.
    model_run(1'b1, 2'd1, 3'd4, 3'd3, 3'd2, 4'd1, 16'h0, 1000, lat, nwr, res, c);
    apply_stimulus(1'b1, 2'd1, 3'd4, 3'd3, 3'd2, 4'd1, 16'h0, 1'b1);
    instr_kind = 1'b0; instr_op = 2'd3; instr_rd = 3'd6;
    instr_rs1 = 3'd5; instr_rs2 = 3'd5; instr_rep = 4'd9; instr_imm = 16'hBEEF;
    check_output(lat, nwr, res, c, 1'b1);
    check("b2b_idle_gap", 32'(busy), 32'd0);
    model_run(1'b0, 2'd3, 3'd6, 3'd5, 3'd5, 4'd9, 16'hBEEF, 1000, lat2, nwr2, res2, c2);
    wr_base = wr_total;
    @(posedge clk);
    #1;
    check("b2b_accepted", 32'(busy), 32'd1);
    instr_valid = 1'b0;
    check_output(lat2, nwr2, res2, c2, 1'b1);
    check("b2b_din", 32'(last_din), 32'hBEEF);

    // Randomized instructions.
    for (int t = 0; t < 20; t++) begin
      do_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
               16'($urandom));
    end

    // Reset during the second write-back of a rep=3 instruction.
    model_run(1'b1, 2'd0, 3'd5, 3'd5, 3'd6, 4'd3, 16'h0, 1, lat, nwr, res, c);
    apply_stimulus(1'b1, 2'd0, 3'd5, 3'd5, 3'd6, 4'd3, 16'h0, 1'b0);
    seen = 0;
    for (int k = 0; k < 40 && seen < 2; k++) begin
      @(negedge clk);
      if (wr) seen++;
    end
    check("reset_reached_wb2", 32'(seen), 32'd2);
    reset = 1'b1;
    #1;
    check("midrst_wr", 32'(wr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(instr_ready), 32'd1);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_writes", 32'(wr_total - wr_base), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("midrst_reg%0d", i), 32'(regs[i]), 32'(model_regs[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alureg_seq_ctrl.md
Name: alureg_seq_ctrl

Overview:
- Micro-sequencer that drives the 8x16 register-file/ALU datapath: accepts one instruction at a time over a valid/ready handshake.
- Generates the datapath controls: read addresses, ALU op, write address, write enable and the write-back mux select.
- Supports immediate load, a single ALU operation, and a repeated ALU operation (iterate count) for accumulate-style sequences.
- Captures the final ALU result and carry, then pulses done.

Parameters:
- DATA_W, 16, datapath word width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- REP_W, 4, iterate-count field width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept an instruction
- instr_kind  in  1  0 = LOADI, 1 = ALU
- instr_op  in  2  ALU operation code, passed to datapath op
- instr_rd  in  ADDR_W  destination register
- instr_rs1  in  ADDR_W  source A register
- instr_rs2  in  ADDR_W  source B register
- instr_rep  in  REP_W  extra iterations (ALU executes rep+1 times)
- instr_imm  in  DATA_W  immediate for LOADI
- op  out  2  to datapath ALU op
- rd_addr_a  out  ADDR_W  to datapath read port A
- rd_addr_b  out  ADDR_W  to datapath read port B
- wr_addr  out  ADDR_W  to datapath write address
- wr  out  1  to datapath write enable
- sel  out  1  to datapath write mux; 1 = ALU result, 0 = d_in
- d_in  out  DATA_W  to datapath external write data
- alu_out  in  DATA_W  from datapath
- cout  in  1  from datapath
- result  out  DATA_W  last written ALU/LOADI value
- carry_flag  out  1  see Optional Feature
- done  out  1  one-cycle pulse at instruction completion
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset is asynchronous, active-high. Immediate effect: state=IDLE; all latched fields, result, carry_flag and iter count = 0; outputs op, rd_addr_a, rd_addr_b, wr_addr, d_in = 0; wr, sel, done, busy = 0; instr_ready = 1.
- Reset mid-instruction abandons it. Any datapath write not yet issued is not issued.
- Handshake:
  - Accept when instr_valid && instr_ready on a rising edge.
  - All instr_* fields are latched at accept; later changes are ignored.
  - instr_ready = (state==IDLE).
- FSM states: IDLE, LOAD, EXEC, WB, DONE.
  - IDLE: on accept, go to LOAD if kind=0, else EXEC; load iter counter with instr_rep.
  - LOAD (1 cycle): wr=1, sel=0, d_in=imm, wr_addr=rd; result<=imm. Next state DONE.
  - EXEC (1 cycle): rd_addr_a=rs1, rd_addr_b=rs2, op=op_latched, wr=0. Next state WB.
  - WB (1 cycle):
    - Read addresses and op held; wr=1, sel=1, wr_addr=rd.
    - result<=alu_out; carry sampled from cout.
    - If iter==0, go to DONE; else iter<=iter-1 and return to EXEC.
    - EXEC re-reads registers, so if rd==rs1 the updated value is used (accumulate).
  - DONE (1 cycle): done=1, then IDLE.
- Outputs are registered per state. Controls hold their last values in IDLE/DONE, except wr, which is 0 outside LOAD/WB.
- Latency, accept to done pulse:
  - LOADI: 2 cycles.
  - ALU: 2*(rep+1)+1 cycles.
  - Next accept is possible the cycle after done.
- Widths: iter counter is REP_W bits and never underflows (checked at 0 before decrement). rep = 2**REP_W-1 gives 2**REP_W iterations.
- instr_valid while busy: held off by instr_ready=0, no loss.

Optional Feature:
- Macro: ALUREG_SEQ_CARRY_EN.
- Defined:
  - carry_flag is a sticky register, set in WB when cout=1.
  - It is cleared at each accept and on reset, so it reports "any carry during this instruction".
  - LOADI leaves it 0.
- Undefined: carry_flag tied to 0; cout is unused.

Decomposition:
- Shared package alureg_pkg:
  - FSM state enum.
  - Instruction kind constants KIND_LOADI=0, KIND_ALU=1.
  - ALU op code constants (2-bit), matching the datapath ALU.
- No sub-module needed. The iteration counter stays inline.
- Top-level test harness instantiates alureg_seq_ctrl plus the existing register-file/ALU datapath.

Test Plan:
- Reset: assert reset mid-WB of a rep=3 ALU instruction -> next edge-independent: wr=0, busy=0, instr_ready=1, result=0; no further register writes.
- LOADI r2=16'h1234 -> wr high exactly one cycle with sel=0, d_in=16'h1234, wr_addr=2; done 2 cycles after accept; result=16'h1234.
- ALU add, r1=5, r2=7, rd=r3, rep=0 -> one write of 12 into r3 with sel=1; done 3 cycles after accept; result=12.
- Accumulate add, r1=1, r2=1, rd=r1, rs1=r1, rs2=r2, rep=3 -> r1 goes 2,3,4,5; four wr pulses; done 9 cycles after accept; result=5.
- Carry (ALUREG_SEQ_CARRY_EN): add r1=16'hFFFF + r2=1 -> result=0, carry_flag=1; the next LOADI accept clears carry_flag to 0.
- Back-to-back: instr_valid held high with two instructions -> second is accepted the cycle after the first done pulse; fields changed while busy are ignored.
